addr_decode_ws: RTL

//  Registered, parametrised successor to the combinational address selector.

---
 rtl/addr_decode_ws.sv | 103 ++++++++++
 1 files changed

// File: rtl/addr_decode_ws.sv
// rtl/addr_decode_ws.sv - registered bus address decoder with RAM wait states and READY/ERR handshake
module addr_decode_ws #(
    parameter int                ADDR_W   = 16,
    parameter int                NUM_REGS = 17,
    parameter logic [ADDR_W-1:0] RAM_TOP  = 16'hFFFF,
    parameter int                RAM_WAIT = 2
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                REQ,
    input  logic                WE,
    input  logic [ADDR_W-1:0]   ADD,
    output logic [NUM_REGS-1:0] REG_SEL,
    output logic                RAM_S,
    output logic                WE_O,
    output logic [ADDR_W-1:0]   ADD_O,
    output logic                READY,
    output logic                ERR,
    output logic                BUSY
);

    typedef enum logic [1:0] {S_IDLE, S_REG, S_RAM, S_ERR} state_t;

    localparam logic [ADDR_W-1:0]   REG_LIMIT = ADDR_W'(NUM_REGS);
    localparam logic [3:0]          WAIT_C    = 4'(RAM_WAIT);
    localparam logic [NUM_REGS-1:0] ONE_HOT0  = NUM_REGS'(1);

    state_t                state_q;
    logic [NUM_REGS-1:0]   reg_sel_q;
    logic                  ram_s_q;
    logic                  we_q;
    logic [ADDR_W-1:0]     add_q;
    logic                  ready_q;
    logic                  err_q;
    logic                  busy_q;
    logic [3:0]            cnt_q;

    logic accept;
    logic is_reg;
    logic is_err;

    // A READY cycle doubles as an accept slot so accesses can run back-to-back.
    assign accept = REQ & ((state_q == S_IDLE) | ready_q);
    assign is_reg = (ADD < REG_LIMIT);
    assign is_err = (ADD > RAM_TOP);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            reg_sel_q <= '0;
            ram_s_q   <= 1'b0;
            we_q      <= 1'b0;
            add_q     <= '0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            if (accept) begin
                add_q     <= ADD;
                we_q      <= WE;
                reg_sel_q <= '0;
                ram_s_q   <= 1'b0;
                if (is_reg) begin
                    state_q   <= S_REG;
                    reg_sel_q <= ONE_HOT0 << ADD;
                    ready_q   <= 1'b1;
                end else if (is_err) begin
                    state_q <= S_ERR;
                    ready_q <= 1'b1;
                    err_q   <= 1'b1;
                end else begin
                    state_q <= S_RAM;
                    ram_s_q <= 1'b1;
                    cnt_q   <= WAIT_C;
                    ready_q <= (WAIT_C == 4'd0);
                    busy_q  <= (WAIT_C != 4'd0);
                end
            end else if (state_q == S_RAM && !ready_q) begin
                // READY lands in the cycle the wait counter shows zero.
                cnt_q   <= cnt_q - 4'd1;
                ready_q <= (cnt_q == 4'd1);
                busy_q  <= (cnt_q != 4'd1);
            end else begin
                state_q   <= S_IDLE;
                reg_sel_q <= '0;
                ram_s_q   <= 1'b0;
            end
        end
    end

    assign REG_SEL = reg_sel_q;
    assign RAM_S   = ram_s_q;
    assign WE_O    = we_q;
    assign ADD_O   = add_q;
    assign READY   = ready_q;
    assign ERR     = err_q;
    assign BUSY    = busy_q;

endmodule
